// File: rtl/pipelined_ks_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake.
// Stage 0 forms the per-bit propagate/generate terms and folds the carry-in
// into G[0]. Stages 1..LOG2W each register one prefix level. The final stage
// registers sum, cout and ovf. All stages advance together whenever the
// output register is empty or being consumed.
module pipelined_ks_adder #(
    parameter int WIDTH = 16,
    parameter int LOG2W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Index LOG2W is the last prefix level; index 0 is the operand stage.
    logic [LOG2W:0] vld_q,  vld_d;
    logic [LOG2W:0] sub_q,  sub_d;
    logic [LOG2W:0] cin_q,  cin_d;
    logic [WIDTH-1:0] p0_q [0:LOG2W];
    logic [WIDTH-1:0] p0_d [0:LOG2W];
    logic [WIDTH-1:0] p_q  [0:LOG2W];
    logic [WIDTH-1:0] p_d  [0:LOG2W];
    logic [WIDTH-1:0] g_q  [0:LOG2W];
    logic [WIDTH-1:0] g_d  [0:LOG2W];

    logic             out_vld_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             adv;
    logic [WIDTH-1:0] bb;
    logic             c0;
    logic             c0_f;
    logic [WIDTH-1:0] carry;

    // A single advance signal stalls every stage while the output is held.
    assign adv       = !out_vld_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_vld_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Next-state for the operand stage and every prefix level.
    always_comb begin
        int span;
        span = 1;
        // Subtract is a + ~b + 1, so the inverted operand takes a forced carry-in.
        bb = b ^ {WIDTH{sub}};
        c0 = sub | cin;
        vld_d[0] = in_valid;
        sub_d[0] = sub;
        cin_d[0] = cin;
        p0_d[0]  = a ^ bb;
        p_d[0]   = a ^ bb;
        g_d[0]   = a & bb;
        // G[0] absorbs the carry-in so the prefix tree yields true carries.
        g_d[0][0] = (a[0] & bb[0]) | ((a[0] ^ bb[0]) & c0);
        for (int k = 1; k <= LOG2W; k++) begin
            span     = 1 << (k - 1);
            vld_d[k] = vld_q[k-1];
            sub_d[k] = sub_q[k-1];
            cin_d[k] = cin_q[k-1];
            p0_d[k]  = p0_q[k-1];
            p_d[k]   = p_q[k-1];
            g_d[k]   = g_q[k-1];
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= span) begin
                    g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-span]);
                    p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-span];
                end
            end
        end
    end

    // Final stage: carries come from the completed prefix generate terms.
    always_comb begin
        c0_f   = sub_q[LOG2W] | cin_q[LOG2W];
        carry  = {g_q[LOG2W][WIDTH-2:0], c0_f};
        sum_d  = p0_q[LOG2W] ^ carry;
        cout_d = g_q[LOG2W][WIDTH-1];
        ovf_d  = carry[WIDTH-1] ^ cout_d;
    end

    // Valid bits and visible outputs clear asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            out_vld_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (adv) begin
            vld_q     <= vld_d;
            out_vld_q <= vld_q[LOG2W];
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    // Internal datapath registers are qualified by the valid bits only.
    always_ff @(posedge clk) begin
        if (adv) begin
            sub_q <= sub_d;
            cin_q <= cin_d;
            for (int k = 0; k <= LOG2W; k++) begin
                p0_q[k] <= p0_d[k];
                p_q[k]  <= p_d[k];
                g_q[k]  <= g_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_ks_adder.sv
// Directed bench for pipelined_ks_adder (WIDTH=16) with a result scoreboard.
module tb_pipelined_ks_adder;

    localparam int W   = 16;
    localparam int L   = 4;
    localparam int LAT = L + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    pipelined_ks_adder #(.WIDTH(W), .LOG2W(L)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    logic [W+1:0] exp_q [$];
    logic [W+1:0] hold_v;
    logic         hold_f    = 1'b0;
    int           n_out     = 0;
    int           first_out = -1;
    int           last_out  = -1;

    // Golden result {sum, cout, ovf} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         co;
        logic         v;
        if (!s) begin
            t  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            r  = t[W-1:0];
            co = t[W];
            v  = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end else begin
            r  = x - y;
            co = (x >= y);
            v  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end
        return {r, co, v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop/compare on each consumed output, push on each accepted input.
    always @(negedge clk) begin
        if (rst) begin
            hold_f = 1'b0;
        end else begin
            chk("in_ready_eq_adv", in_ready, (!out_valid || out_ready));
            if (hold_f && out_valid) chk("stall_hold", {sum, cout, ovf}, hold_v);
            hold_f = 1'b0;
            if (out_valid) begin
                if (!out_ready) begin
                    hold_f = 1'b1;
                    hold_v = {sum, cout, ovf};
                end else if (exp_q.size() == 0) begin
                    chk("no_stale_beat", out_valid, 1'b0);
                end else begin
                    chk("result", {sum, cout, ovf}, exp_q.pop_front());
                    n_out++;
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic single(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input logic s, input logic [W-1:0] es, input logic ec, input logic ev);
        int lat;
        @(posedge clk); #1;
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, LAT);
        chk("dir_sum", sum, es);
        chk("dir_cout", cout, ec);
        chk("dir_ovf", ovf, ev);
        @(posedge clk); #1;
    endtask

    task automatic stream(input int n, input int stall_at);
        int  waits;
        int  first_acc;
        logic acc;
        n_out = 0;
        first_out = -1;
        first_acc = -1;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            if (i == stall_at) begin
                out_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    chk("stall_out_valid", out_valid, 1'b1);
                    chk("stall_in_ready", in_ready, 1'b0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            waits = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                waits++;
            end while (!acc && waits < 50);
            chk("beat_accepted", acc, 1'b1);
            if (i == 0) first_acc = cyc;
        end
        in_valid = 1'b0;
        waits = 0;
        while ((exp_q.size() != 0 || out_valid) && waits < 100) begin
            @(posedge clk); #1;
            waits++;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("stream_count", n_out, n);
        if (stall_at < 0) begin
            chk("stream_latency", first_out - first_acc + 1, LAT);
            chk("stream_rate", last_out - first_out, n - 1);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        single(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        single(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        single(16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0);
        single(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
        single(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1);

        stream(20, -1);
        stream(20, 10);

        // Three beats in flight, the oldest held at the output, then reset mid-cycle.
        out_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            a = 16'h1111 + W'(i); b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_valid", out_valid, 1'b1);
        chk("pre_rst_sum", sum, 16'h3333);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_sum", sum, 16'h0000);
        chk("async_rst_cout", cout, 1'b0);
        chk("async_rst_ovf", ovf, 1'b0);
        chk("async_rst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        single(16'hABCD, 16'h1234, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        chk("post_rst_idle_valid", out_valid, 1'b0);
        chk("post_rst_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
